// File: rtl/dds_param_regfile.sv
// Shadow/active parameter register file for a two-channel DDS/PWM generator.
// Optional macro DDS_PARAM_READBACK_EN adds a registered shadow readback port (rd_id/rd_data).
//
// state    | meaning
// S_IDLE   | accepting writes; a pending copy lands on the edge that leaves the cycle after COMMIT
// S_COMMIT | one-cycle stall, clears dirty and arms the shadow-to-active copy
module dds_param_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        param_valid,
    output logic        param_ready,
    input  logic [7:0]  param_id,
    input  logic [31:0] param_value,
    output logic [31:0] dds_frequency_A,
    output logic [31:0] dds_frequency_B,
    output logic [13:0] dds_phase_A,
    output logic [13:0] dds_phase_B,
    output logic [4:0]  dds_Amplitude_A,
    output logic [4:0]  dds_Amplitude_B,
    output logic [2:0]  dds_wave_type_A,
    output logic [2:0]  dds_wave_type_B,
    output logic        dds_choose_en_A,
    output logic        dds_choose_en_B,
    output logic [13:0] vol_bias_A,
    output logic [13:0] vol_bias_B,
    output logic [7:0]  duty_cycle_A,
    output logic [7:0]  duty_cycle_B,
    output logic [31:0] div_fractor_A,
    output logic [31:0] div_fractor_B,
    output logic [1:0]  dds_pwm_choose,
    output logic        param_update,
    output logic        id_err
`ifdef DDS_PARAM_READBACK_EN
    ,
    input  logic [7:0]  rd_id,
    output logic [31:0] rd_data
`endif
);

    typedef enum logic {S_IDLE = 1'b0, S_COMMIT = 1'b1} state_t;

    typedef struct packed {
        logic [31:0] freq;
        logic [13:0] phase;
        logic [4:0]  amp;
        logic [2:0]  wave;
        logic        choose_en;
        logic [13:0] bias;
        logic [7:0]  duty;
        logic [31:0] div;
    } ch_t;

    localparam ch_t CH_DEFAULT = '{freq: 32'd0, phase: 14'd0, amp: 5'd31, wave: 3'd0,
                                   choose_en: 1'b0, bias: 14'd0, duty: 8'd50, div: 32'd1};

    localparam logic [7:0] ID_PWM     = 8'h20;
    localparam logic [7:0] ID_COMMIT  = 8'hF0;
    localparam logic [7:0] ID_DISCARD = 8'hF1;
    localparam logic [7:0] ID_CLR_ERR = 8'hF2;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        copy_q, copy_d;
    logic        update_q, update_d;
    logic        dirty_q, dirty_d;
    logic        err_q, err_d;
    ch_t         sh_q [2];
    ch_t         sh_d [2];
    ch_t         act_q [2];
    ch_t         act_d [2];
    logic [1:0]  pwm_sh_q, pwm_sh_d;
    logic [1:0]  pwm_act_q, pwm_act_d;

    logic        accept;
    logic        is_field;
    logic        ch_sel;

    function automatic ch_t put_field(input ch_t c, input logic [2:0] f, input logic [31:0] v);
        ch_t r;
        r = c;
        case (f)
            3'd0: r.freq      = v;
            3'd1: r.phase     = v[13:0];
            3'd2: r.amp       = (v > 32'd31) ? 5'd31 : v[4:0];
            3'd3: r.wave      = v[2:0];
            3'd4: r.choose_en = v[0];
            3'd5: r.bias      = v[13:0];
            3'd6: r.duty      = (v > 32'd100) ? 8'd100 : v[7:0];
            default: r.div    = (v == 32'd0) ? 32'd1 : v;
        endcase
        return r;
    endfunction

    assign accept   = param_valid && ready_q;
    assign is_field = (param_id[7:5] == 3'b000) && !param_id[3];
    assign ch_sel   = param_id[4];

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        copy_d    = 1'b0;
        update_d  = 1'b0;
        dirty_d   = dirty_q;
        err_d     = err_q;
        sh_d      = sh_q;
        act_d     = act_q;
        pwm_sh_d  = pwm_sh_q;
        pwm_act_d = pwm_act_q;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                // The armed copy reads the pre-edge shadow, so a write landing on this edge stays shadow-only.
                if (copy_q) begin
                    act_d     = sh_q;
                    pwm_act_d = pwm_sh_q;
                    update_d  = 1'b1;
                end
                if (accept) begin
                    if (is_field) begin
                        sh_d[ch_sel] = put_field(sh_q[ch_sel], param_id[2:0], param_value);
                        dirty_d      = 1'b1;
                    end else begin
                        case (param_id)
                            ID_PWM: begin
                                pwm_sh_d = param_value[1:0];
                                dirty_d  = 1'b1;
                            end
                            ID_COMMIT: begin
                                if (dirty_q) begin
                                    state_d = S_COMMIT;
                                    ready_d = 1'b0;
                                end
                            end
                            ID_DISCARD: begin
                                // With a copy landing now, the shadow already equals the incoming active set.
                                if (!copy_q) begin
                                    sh_d     = act_q;
                                    pwm_sh_d = pwm_act_q;
                                end
                                dirty_d = 1'b0;
                            end
                            ID_CLR_ERR: err_d = 1'b0;
                            default:    err_d = 1'b1;
                        endcase
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                copy_d  = 1'b1;
                dirty_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            copy_q    <= 1'b0;
            update_q  <= 1'b0;
            dirty_q   <= 1'b0;
            err_q     <= 1'b0;
            sh_q[0]   <= CH_DEFAULT;
            sh_q[1]   <= CH_DEFAULT;
            act_q[0]  <= CH_DEFAULT;
            act_q[1]  <= CH_DEFAULT;
            pwm_sh_q  <= 2'd0;
            pwm_act_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            copy_q    <= copy_d;
            update_q  <= update_d;
            dirty_q   <= dirty_d;
            err_q     <= err_d;
            sh_q      <= sh_d;
            act_q     <= act_d;
            pwm_sh_q  <= pwm_sh_d;
            pwm_act_q <= pwm_act_d;
        end
    end

    assign param_ready     = ready_q;
    assign param_update    = update_q;
    assign id_err          = err_q;
    assign dds_frequency_A = act_q[0].freq;
    assign dds_frequency_B = act_q[1].freq;
    assign dds_phase_A     = act_q[0].phase;
    assign dds_phase_B     = act_q[1].phase;
    assign dds_Amplitude_A = act_q[0].amp;
    assign dds_Amplitude_B = act_q[1].amp;
    assign dds_wave_type_A = act_q[0].wave;
    assign dds_wave_type_B = act_q[1].wave;
    assign dds_choose_en_A = act_q[0].choose_en;
    assign dds_choose_en_B = act_q[1].choose_en;
    assign vol_bias_A      = act_q[0].bias;
    assign vol_bias_B      = act_q[1].bias;
    assign duty_cycle_A    = act_q[0].duty;
    assign duty_cycle_B    = act_q[1].duty;
    assign div_fractor_A   = act_q[0].div;
    assign div_fractor_B   = act_q[1].div;
    assign dds_pwm_choose  = pwm_act_q;

`ifdef DDS_PARAM_READBACK_EN
    logic [31:0] rd_data_q, rd_data_d;

    function automatic logic [31:0] field_of(input ch_t c, input logic [2:0] f);
        case (f)
            3'd0:    return c.freq;
            3'd1:    return {18'd0, c.phase};
            3'd2:    return {27'd0, c.amp};
            3'd3:    return {29'd0, c.wave};
            3'd4:    return {31'd0, c.choose_en};
            3'd5:    return {18'd0, c.bias};
            3'd6:    return {24'd0, c.duty};
            default: return c.div;
        endcase
    endfunction

    always_comb begin
        rd_data_d = 32'd0;
        if ((rd_id[7:5] == 3'b000) && !rd_id[3]) begin
            rd_data_d = field_of(sh_q[rd_id[4]], rd_id[2:0]);
        end else if (rd_id == ID_PWM) begin
            rd_data_d = {30'd0, pwm_sh_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rd_data_q <= 32'd0;
        else        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
`endif

endmodule
